// File: rtl/sysbus_mem_responder.sv
// Memory-side responder for the cache<->DRAM system bus: 8-beat line reads and writes
// against an internal line store, with a peer-cache invalidate broadcast after each write.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int OFFSET         = 6,
    parameter int MEM_LINES      = 64,
    parameter int READ_LATENCY   = 4,
    parameter bit INV_ENABLE     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic [BUS_DATA_WIDTH-1:0] inv_req,
    input  logic                      invalidated,
    output logic                      busy
);

    localparam int BEATS = 8;
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [2:0] LAST_BEAT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK_REQ,
        ST_RD_WAIT,
        ST_RD_BEAT,
        ST_RD_GAP,
        ST_WR_CAP,
        ST_WR_ACK,
        ST_INV
    } state_e;

    state_e                    state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [2:0]                beat_q, beat_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic                      reqack_q, respcyc_q, busy_q;
    logic [BUS_DATA_WIDTH-1:0] resp_q, inv_req_q;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q;

    logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_LINES*BEATS];
    logic [IDX_W-1:0]          line_idx;
    logic                      mem_we;
    logic [BUS_DATA_WIDTH-1:0] rd_word;

    // Index wraps modulo MEM_LINES because only the low line-address bits are used.
    assign line_idx = addr_q[OFFSET +: IDX_W];
    assign rd_word  = mem_q[{line_idx, beat_d}];

    // NOTE: the line store has no reset; reset only aborts the transfer, stored beats persist.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[{line_idx, beat_q}] <= bus_req;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_reqcyc) begin
                    addr_d  = {bus_req[BUS_DATA_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
                    tag_d   = bus_reqtag;
                    state_d = ST_ACK_REQ;
                end
            end
            ST_ACK_REQ: begin
                beat_d = '0;
                if (tag_q[BUS_TAG_WIDTH-1]) begin
                    state_d = ST_WR_CAP;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) state_d = ST_RD_BEAT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RD_BEAT: begin
                if (bus_respack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = ST_RD_GAP;
                    end
                end
            end
            ST_RD_GAP: state_d = ST_RD_BEAT;
            ST_WR_CAP: begin
                if (bus_reqcyc) begin
                    mem_we  = !reset;
                    state_d = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    // Line address 0 doubles as the "no invalidate" encoding.
                    state_d = (INV_ENABLE && addr_q != '0) ? ST_INV : ST_IDLE;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    state_d = ST_WR_CAP;
                end
            end
            ST_INV: begin
                if (invalidated) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
            inv_req_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            reqack_q  <= (state_d == ST_ACK_REQ) || (state_d == ST_WR_ACK);
            respcyc_q <= (state_d == ST_RD_BEAT);
            resp_q    <= (state_d == ST_RD_BEAT) ? rd_word : '0;
            resptag_q <= (state_d == ST_RD_BEAT) ? tag_d : '0;
            inv_req_q <= (state_d == ST_INV) ? addr_d : '0;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;
    assign inv_req     = inv_req_q;
    assign busy        = busy_q;

endmodule
